// File: rtl/pipe_skid_reg.sv
// Single-entry pipeline register with a one-beat skid buffer, stall/flush
// control and a saturating transfer counter. in_ready never sees out_ready.
module pipe_skid_reg #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  xfer_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = !reset && !hold && (state != SKID);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occ       = state;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready && !hold && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
    end else if (!hold) begin
      if (flush) begin
        // Any beat offered this cycle is swallowed by the flush.
        state  <= EMPTY;
        main_q <= FLUSH_VAL;
        skid_q <= FLUSH_VAL;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              state  <= FULL;
              main_q <= in_data;
            end
          end
          FULL: begin
            case ({in_fire, out_fire})
              2'b11: main_q <= in_data;
              2'b10: begin
                state  <= SKID;
                skid_q <= in_data;
              end
              2'b01: state <= EMPTY;
              default: ;
            endcase
          end
          SKID: begin
            if (out_fire) begin
              state  <= FULL;
              main_q <= skid_q;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_cnt <= '0;
    end else if (!hold) begin
      if (cnt_clr)
        xfer_cnt <= '0;
      else if (out_fire && xfer_cnt != CNT_MAX)
        xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Checks pipe_skid_reg against a queue-based model: directed scenarios
// followed by randomized hold/flush/backpressure traffic.
module tb_pipe_skid_reg;

  localparam int          DATA_W = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] FV     = 32'hDEAD_BEEF;
  localparam int          CMAX   = 15;

  logic              clk;
  logic              reset;
  logic              hold;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
  logic              cnt_clr;
  logic [CNT_W-1:0]  xfer_cnt;

  int checks = 0;
  int fails  = 0;

  // Model: queue of held beats, the value main shows when idle, and the count.
  logic [31:0] q[$];
  logic [31:0] idle_val;
  int          cnt;

  pipe_skid_reg #(.DATA_W(DATA_W), .FLUSH_VAL(FV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ), .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    idle_val = FV;
    cnt      = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : idle_val;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, !reset && !hold && q.size() < 2});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk({tag, ".out_data"}, out_data, exp_data);
    chk({tag, ".occ"}, {30'd0, occ}, q.size());
    chk({tag, ".xfer_cnt"}, {28'd0, xfer_cnt}, cnt);
  endtask

  // Drive one cycle of inputs, check pre-edge outputs, then advance the model.
  task automatic step(input string tag, input logic h, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy, input logic cc);
    bit ofire, ifire;
    hold = h; flush = f; in_valid = iv; in_data = d; out_ready = ordy; cnt_clr = cc;
    #1;
    check_outputs(tag);
    @(posedge clk);
    #1;
    if (!h) begin
      if (f) begin
        q.delete();
        idle_val = FV;
        if (cc) cnt = 0;
      end else begin
        ofire = (q.size() > 0) && ordy;
        ifire = iv && (q.size() < 2);
        if (ofire) idle_val = q.pop_front();
        if (ifire) q.push_back(d);
        if (cc) cnt = 0;
        else if (ofire && cnt < CMAX) cnt++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rel.in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming at full rate
    step("st0", 0, 0, 1, 32'h11, 1, 0);
    step("st1", 0, 0, 1, 32'h22, 1, 0);
    step("st2", 0, 0, 1, 32'h33, 1, 0);
    step("st3", 0, 0, 0, 32'h0, 1, 0);
    step("st4", 0, 0, 0, 32'h0, 1, 0);
    chk("st.cnt3", {28'd0, xfer_cnt}, 32'd3);

    // Backpressure fills the skid, then drains in order
    step("bp0", 0, 0, 1, 32'hA0, 0, 0);
    step("bp1", 0, 0, 1, 32'hA1, 0, 0);
    step("bp2", 0, 0, 1, 32'hA2, 0, 0);
    chk("bp.occ2", {30'd0, occ}, 32'd2);
    step("bp3", 0, 0, 1, 32'hA2, 1, 0);
    step("bp4", 0, 0, 1, 32'hA2, 1, 0);
    step("bp5", 0, 0, 0, 32'h0, 1, 0);
    step("bp6", 0, 0, 0, 32'h0, 1, 0);

    // Flush while in SKID with a beat offered
    step("fl0", 0, 0, 1, 32'hC0, 0, 0);
    step("fl1", 0, 0, 1, 32'hC1, 0, 0);
    step("fl2", 0, 1, 1, 32'hBB, 1, 0);
    chk("fl.data", out_data, FV);
    step("fl3", 0, 0, 0, 32'h0, 1, 0);

    // Hold masks flush and out_ready
    step("hf0", 0, 0, 1, 32'h55, 0, 0);
    for (int i = 0; i < 3; i++) step("hf1", 1, 1, 0, 32'h0, 1, 0);
    chk("hf.data", out_data, 32'h55);
    step("hf2", 0, 0, 0, 32'h0, 1, 0);
    step("hf3", 0, 0, 0, 32'h0, 1, 0);

    // Counter saturation and clear-over-increment
    step("sat0", 0, 0, 0, 32'h0, 1, 1);
    for (int i = 0; i < 21; i++) step("sat1", 0, 0, 1, 32'h100 + i, 1, 0);
    chk("sat.max", {28'd0, xfer_cnt}, 32'd15);
    step("sat2", 0, 0, 1, 32'h200, 1, 1);
    chk("sat.clr", {28'd0, xfer_cnt}, 32'd0);
    step("sat3", 0, 0, 0, 32'h0, 1, 0);

    // Async reset between edges while holding two beats
    step("ar0", 0, 0, 1, 32'hE0, 0, 0);
    step("ar1", 0, 0, 1, 32'hE1, 0, 0);
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("ar.mid");
    reset = 1'b0;
    #1;
    check_outputs("ar.rel");
    step("ar2", 0, 0, 1, 32'hE5, 1, 0);
    step("ar3", 0, 0, 0, 32'h0, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Parameters
REQ-001 DATA_W, default 32, payload width in bits (legal range 1..256).
REQ-002 FLUSH_VAL, default 0 (DATA_W bits), payload value loaded on reset and on flush, i.e. the NOP encoding.
REQ-003 CNT_W, default 16, transfer-counter width (legal range 4..32).

Interface
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 hold  in  1  pipeline stall; freezes all state and blocks both handshakes.
REQ-007 flush  in  1  synchronous flush; honoured only when hold=0.
REQ-008 in_valid  in  1  upstream beat present.
REQ-009 in_ready  out  1  stage can accept a beat.
REQ-010 in_data  in  DATA_W  upstream payload.
REQ-011 out_valid  out  1  downstream beat present.
REQ-012 out_ready  in  1  downstream accepts the beat.
REQ-013 out_data  out  DATA_W  downstream payload, driven from the main register.
REQ-014 occ  out  2  occupancy: 0, 1 or 2 beats held.
REQ-015 cnt_clr  in  1  synchronous clear of xfer_cnt.
REQ-016 xfer_cnt  out  CNT_W  saturating count of out_fire events.

Function
REQ-017 Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & !hold & !flush.
REQ-018 Storage is two registers: main (drives out_data) and skid (overflow).
REQ-019 FSM states are EMPTY (occ=0), FULL (occ=1, main valid), SKID (occ=2, main and skid valid); encoding is free.
REQ-020 in_ready = !reset & !hold & (state != SKID), decoded from registered state only, with no combinational path from out_ready.
REQ-021 out_valid = (state != EMPTY); it is not gated by hold.
REQ-022 EMPTY: in_fire -> FULL with main <= in_data, latency 1 cycle from input to output.
REQ-023 FULL: in_fire & out_fire -> stay FULL with main <= in_data; in_fire only -> SKID with skid <= in_data; out_fire only -> EMPTY; no fire -> hold state.
REQ-024 SKID: out_fire -> FULL with main <= skid; no fire -> hold state; in_fire is impossible because in_ready=0.
REQ-025 Ordering is strict FIFO; no beat is duplicated, reordered or lost, except on flush.
REQ-026 When hold=1, state, main, skid and xfer_cnt are frozen; flush and cnt_clr are ignored; in_ready=0.
REQ-027 When hold=0 and flush=1, the next state is EMPTY and main and skid are loaded with FLUSH_VAL.
REQ-028 A flush overrides any simultaneous in_fire; that beat counts as consumed and is discarded.
REQ-029 During a flush cycle, out_fire is suppressed and xfer_cnt does not increment.
REQ-030 xfer_cnt increments by 1 on each out_fire and saturates at 2^CNT_W-1 with no wrap.
REQ-031 cnt_clr=1 with hold=0 loads 0; clear has priority over a simultaneous increment.
REQ-032 The skid register loads only on the FULL -> SKID transition and otherwise retains its value.
REQ-033 Sustained throughput is 1 beat per cycle when out_ready=1 and hold=0.

Reset
REQ-034 While reset=1 (asynchronous): state=EMPTY, main=skid=FLUSH_VAL, out_valid=0, occ=0, xfer_cnt=0, in_ready=0.
REQ-035 Reset asserted mid-operation discards all held beats immediately, without waiting for a clock edge.
REQ-036 After reset deasserts, in_ready=1 in the same cycle if hold=0.

Verification
REQ-037 Streaming: DATA_W=32, out_ready=1, in 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each; occ=1 throughout; xfer_cnt=3.
REQ-038 Backpressure: out_ready=0, offer 0xA0,0xA1,0xA2 -> 0xA0,0xA1 accepted, occ=2, in_ready=0; then out_ready=1 -> output order 0xA0,0xA1,0xA2, with none lost.
REQ-039 Flush in SKID with in_valid=1 (0xBB) -> next cycle occ=0, out_valid=0, out_data=FLUSH_VAL; 0xBB never appears at the output; xfer_cnt unchanged.
REQ-040 Hold and flush together: state FULL holding 0x55, hold=1, flush=1, out_ready=1 for 3 cycles -> out_data stays 0x55, occ=1, xfer_cnt frozen; release hold -> 0x55 transfers.
REQ-041 Saturation: CNT_W=4, 20 back-to-back transfers -> xfer_cnt=15; cnt_clr together with an out_fire -> xfer_cnt=0.
REQ-042 Async reset asserted between clock edges while occ=2 -> out_valid=0 and occ=0 before the next edge; first beat after deassert appears at the output 1 cycle later.
